// File: rtl/reg_writeback.sv
// -----------------------------------------------------------------------------
// reg_writeback
//
// Write-side initiator for the integer register file. Results from the
// single-cycle ALU path and the variable-latency LSU are merged onto the
// register file's single write port. A per-register pending-write scoreboard
// lets the issue stage stall on RAW hazards.
//
// Ports
//   clk           : single clock, all state on the rising edge
//   reset         : asynchronous, active-low; clears all state while low
//   alloc_valid   : issue stage claims alloc_addr as a pending destination
//   alloc_addr    : destination register being claimed
//   chk_addr1/2   : source registers to test for pending writes
//   chk_busy1/2   : source has at least one pending write (combinational)
//   alu_valid     : ALU result present
//   alu_ready     : ALU result accepted when high together with alu_valid
//   alu_addr/data : ALU destination and result
//   lsu_valid     : LSU result present
//   lsu_ready     : LSU result FIFO can accept a result
//   lsu_addr/data : LSU destination and result
//   write_enable  : registered register-file write strobe
//   write_addr    : registered register-file write address
//   write_data    : registered register-file write data
//   sb_overflow   : sticky, allocation attempted on a saturated counter
// -----------------------------------------------------------------------------
module reg_writeback #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 32,
  parameter int ADDR_W = $clog2(SIZE),
  parameter int DEPTH  = 4,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [WIDTH-1:0]  lsu_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic              sb_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE + 1);

  // ---------------------------------------------------------------------------
  // LSU result FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [WIDTH-1:0]  fifo_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(DEPTH));

  // Full blocks pushes even when a pop happens in the same cycle, so
  // lsu_ready depends only on registered state.
  assign lsu_ready = !fifo_full;
  assign push      = lsu_valid && !fifo_full;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [STV_W-1:0]  starve_cnt;
  logic              starve_hit;
  logic              alu_take;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic              issue;

  // A waiting LSU entry that has been passed over STARVE times wins over
  // the ALU; otherwise the ALU has priority and the FIFO fills idle slots.
  // The head entry is only visible from the registered count, so an entry
  // can never be popped in the cycle it is pushed.
  assign starve_hit = (starve_cnt >= STV_W'(STARVE)) && !fifo_empty;
  assign alu_ready  = !starve_hit;
  assign alu_take   = alu_valid && !starve_hit;
  assign pop        = !fifo_empty && (starve_hit || !alu_valid);

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (pop) begin
      sel_valid = 1'b1;
      sel_addr  = fifo_addr[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end else if (alu_take) begin
      sel_valid = 1'b1;
      sel_addr  = alu_addr;
      sel_data  = alu_data;
    end
  end

  // Results for x0 are consumed but never reach the register file.
  assign issue = sel_valid && (sel_addr != '0);

  // FIFO storage carries no reset; validity comes from the reset count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lsu_addr;
      fifo_data[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Counts cycles the FIFO head has been passed over; the guard keeps it
  // from wrapping, although a hit always forces a pop that clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STV_W'(STARVE)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= issue;
      if (issue) begin
        write_addr <= sel_addr;
        write_data <= sel_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
  logic [1:0] pend      [SIZE];
  logic [1:0] pend_next [SIZE];
  logic       ovf_set;

  // An allocation and a write to the same register on one edge cancel.
  // A lone allocation on a saturated counter flags overflow instead of
  // wrapping; a lone write on an idle counter leaves it at zero.
  always_comb begin
    ovf_set = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      pend_next[i] = pend[i];
    end
    for (int i = 1; i < SIZE; i++) begin
      if (alloc_valid && (alloc_addr == ADDR_W'(i)) &&
          !(issue && (sel_addr == ADDR_W'(i)))) begin
        if (pend[i] == 2'd3) begin
          ovf_set = 1'b1;
        end else begin
          pend_next[i] = pend[i] + 2'd1;
        end
      end else if (issue && (sel_addr == ADDR_W'(i)) &&
                   !(alloc_valid && (alloc_addr == ADDR_W'(i)))) begin
        if (pend[i] != 2'd0) begin
          pend_next[i] = pend[i] - 2'd1;
        end
      end
    end
    pend_next[0] = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) begin
        pend[i] <= 2'd0;
      end
      sb_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        pend[i] <= pend_next[i];
      end
      if (ovf_set) begin
        sb_overflow <= 1'b1;
      end
    end
  end

  // x0 is never busy regardless of what the counter array holds.
  assign chk_busy1 = (chk_addr1 != '0) && (pend[chk_addr1] != 2'd0);
  assign chk_busy2 = (chk_addr2 != '0) && (pend[chk_addr2] != 2'd0);

endmodule

// File: tb/tb_reg_writeback.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback
//
// Self-checking bench for reg_writeback: directed scenarios for each feature
// followed by a randomized run checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_reg_writeback;

  localparam int WIDTH  = 32;
  localparam int SIZE   = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int STARVE = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic [ADDR_W-1:0] alloc_addr;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_busy1;
  logic              chk_busy2;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [WIDTH-1:0]  alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic [WIDTH-1:0]  lsu_data;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [WIDTH-1:0]  write_data;
  logic              sb_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_writeback #(
    .WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE(STARVE)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .sb_overflow(sb_overflow)
  );

  // Reference model: pending counts per register, LSU results as a queue,
  // a passed-over counter for the queue head, and the expected write port.
  int               m_cnt [SIZE];
  int               m_qa  [$];
  logic [WIDTH-1:0] m_qd  [$];
  int               m_starve;
  bit               m_ovf;
  bit               m_we;
  int               m_wa;
  logic [WIDTH-1:0] m_wd;

  function automatic bit m_hit();
    return (m_starve >= STARVE) && (m_qa.size() > 0);
  endfunction

  function automatic bit m_busy(int a);
    return (a != 0) && (m_cnt[a] != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) m_cnt[i] = 0;
    m_qa.delete();
    m_qd.delete();
    m_starve = 0;
    m_ovf    = 0;
    m_we     = 0;
    m_wa     = 0;
    m_wd     = '0;
  endtask

  task automatic model_seq();
    bit hit, pop, take, push, issue;
    int sa, aa;
    logic [WIDTH-1:0] sd;
    hit  = m_hit();
    pop  = (m_qa.size() > 0) && (hit || !alu_valid);
    take = !hit && alu_valid;
    push = lsu_valid && (m_qa.size() < DEPTH);
    sa = 0;
    sd = '0;
    if (pop) begin
      sa = m_qa[0];
      sd = m_qd[0];
    end else if (take) begin
      sa = int'(alu_addr);
      sd = alu_data;
    end
    issue = (pop || take) && (sa != 0);
    aa = int'(alloc_addr);
    if (alloc_valid && aa != 0 && !(issue && sa == aa)) begin
      if (m_cnt[aa] == 3) m_ovf = 1;
      else m_cnt[aa]++;
    end
    if (issue && !(alloc_valid && aa == sa) && m_cnt[sa] > 0) m_cnt[sa]--;
    m_we = issue;
    if (issue) begin
      m_wa = sa;
      m_wd = sd;
    end
    if (pop || m_qa.size() == 0) m_starve = 0;
    else m_starve++;
    if (pop) begin
      void'(m_qa.pop_front());
      void'(m_qd.pop_front());
    end
    if (push) begin
      m_qa.push_back(int'(lsu_addr));
      m_qd.push_back(lsu_data);
    end
  endtask

  // One rising edge; the model follows the DUT, then outputs settle.
  task automatic tick();
    @(posedge clk);
    if (reset) model_seq();
    else model_reset();
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_addr = '0;
    alu_valid   = 0; alu_addr   = '0; alu_data = '0;
    lsu_valid   = 0; lsu_addr   = '0; lsu_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    model_reset();
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    model_reset();
    alu_valid = 1; alu_addr = 5'd9; alu_data = 32'h55;
    lsu_valid = 1; lsu_addr = 5'd4; lsu_data = 32'h66;
    alloc_valid = 1; alloc_addr = 5'd6;
    chk_addr1 = 5'd6; chk_addr2 = 5'd4;
    tick();
    tick();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b expected 0", write_enable); end
    checks++; if (write_addr !== '0) begin failures++; $display("[TB] FAIL reset_waddr: got %0d expected 0", write_addr); end
    checks++; if (write_data !== '0) begin failures++; $display("[TB] FAIL reset_wdata: got %0h expected 0", write_data); end
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_lsu_ready: got %b expected 1", lsu_ready); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_alu_ready: got %b expected 1", alu_ready); end
    checks++; if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b%b expected 00", chk_busy1, chk_busy2); end
    checks++; if (sb_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", sb_overflow); end
    lsu_valid = 0; alloc_valid = 0;
    reset = 1;
    tick();
    checks++; if (write_enable !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'h55) begin
      failures++; $display("[TB] FAIL first_write: got we=%b a=%0d d=%0h expected we=1 a=9 d=55", write_enable, write_addr, write_data); end
    alu_valid = 0;
    tick();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL first_write_once: got %b expected 0", write_enable); end
  endtask

  task automatic test_alu_write();
    idle();
    chk_addr1 = 5'd5;
    alloc_valid = 1; alloc_addr = 5'd5;
    tick();
    alloc_valid = 0;
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (chk_busy1 !== 1'b1) begin failures++; $display("[TB] FAIL alu_busy_before: got %b expected 1", chk_busy1); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("[TB] FAIL alu_ready: got %b expected 1", alu_ready); end
    tick();
    checks++; if (write_enable !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL alu_write: got we=%b a=%0d d=%0h expected we=1 a=5 d=deadbeef", write_enable, write_addr, write_data); end
    checks++; if (chk_busy1 !== 1'b0) begin failures++; $display("[TB] FAIL alu_busy_after: got %b expected 0", chk_busy1); end
    idle();
    tick();
  endtask

  task automatic test_lsu_latency();
    idle();
    lsu_valid = 1; lsu_addr = 5'd20; lsu_data = 32'h77;
    tick();
    lsu_valid = 0;
    checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL lsu_lat_early: got %b expected 0", write_enable); end
    tick();
    checks++; if (write_enable !== 1'b1 || write_addr !== 5'd20 || write_data !== 32'h77) begin
      failures++; $display("[TB] FAIL lsu_lat_write: got we=%b a=%0d d=%0h expected we=1 a=20 d=77", write_enable, write_addr, write_data); end
    tick();
  endtask

  task automatic test_lsu_starve();
    idle();
    alu_valid = 1; alu_addr = 5'd10; alu_data = 32'h100;
    lsu_valid = 1;
    for (int k = 0; k < 4; k++) begin
      lsu_addr = ADDR_W'(11 + k);
      lsu_data = 32'hA0 + k;
      #1;
      checks++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b1) begin
        failures++; $display("[TB] FAIL starve_fill_ready: push %0d got lsu=%b alu=%b expected 1 1", k, lsu_ready, alu_ready); end
      tick();
      checks++; if (write_enable !== 1'b1 || write_addr !== 5'd10) begin
        failures++; $display("[TB] FAIL starve_alu_write: push %0d got we=%b a=%0d expected we=1 a=10", k, write_enable, write_addr); end
    end
    lsu_valid = 0;
    #1;
    checks++; if (lsu_ready !== 1'b0 || alu_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL starve_full: got lsu=%b alu=%b expected 0 1", lsu_ready, alu_ready); end
    tick();
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("[TB] FAIL starve_override: got %b expected 0", alu_ready); end
    tick();
    checks++; if (write_enable !== 1'b1 || write_addr !== 5'd11 || write_data !== 32'hA0) begin
      failures++; $display("[TB] FAIL starve_first_lsu: got we=%b a=%0d d=%0h expected we=1 a=11 d=a0", write_enable, write_addr, write_data); end
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("[TB] FAIL starve_ready_back: got %b expected 1", lsu_ready); end
    alu_valid = 0;
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++; if (write_enable !== 1'b1 || write_addr !== ADDR_W'(11 + k) || write_data !== 32'hA0 + k) begin
        failures++; $display("[TB] FAIL starve_order: entry %0d got we=%b a=%0d d=%0h expected a=%0d", k, write_enable, write_addr, write_data, 11 + k); end
    end
    tick();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL starve_drained: got %b expected 0", write_enable); end
  endtask

  task automatic test_overflow();
    idle();
    chk_addr1 = 5'd7;
    alloc_valid = 1; alloc_addr = 5'd7;
    repeat (3) tick();
    checks++; if (chk_busy1 !== 1'b1 || sb_overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL ovf_three: got busy=%b ovf=%b expected 1 0", chk_busy1, sb_overflow); end
    tick();
    checks++; if (sb_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set: got %b expected 1", sb_overflow); end
    alloc_valid = 0;
    alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h7;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (chk_busy1 !== (k < 2)) begin
        failures++; $display("[TB] FAIL ovf_drain: write %0d got busy=%b expected %b", k, chk_busy1, k < 2); end
    end
    checks++; if (sb_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b expected 1", sb_overflow); end
    idle();
    tick();
  endtask

  task automatic test_x0();
    idle();
    chk_addr1 = 5'd0;
    alloc_valid = 1; alloc_addr = 5'd0;
    alu_valid = 1; alu_addr = 5'd0; alu_data = 32'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("[TB] FAIL x0_ready: got %b expected 1", alu_ready); end
    tick();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL x0_we: got %b expected 0", write_enable); end
    checks++; if (chk_busy1 !== 1'b0) begin failures++; $display("[TB] FAIL x0_busy: got %b expected 0", chk_busy1); end
    idle();
    tick();
  endtask

  task automatic test_same_edge();
    idle();
    chk_addr1 = 5'd3;
    alloc_valid = 1; alloc_addr = 5'd3;
    tick();
    alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h33;
    tick();
    checks++; if (write_enable !== 1'b1 || write_addr !== 5'd3) begin
      failures++; $display("[TB] FAIL same_edge_write: got we=%b a=%0d expected we=1 a=3", write_enable, write_addr); end
    checks++; if (chk_busy1 !== 1'b1) begin failures++; $display("[TB] FAIL same_edge_busy: got %b expected 1", chk_busy1); end
    alloc_valid = 0;
    tick();
    checks++; if (chk_busy1 !== 1'b0) begin failures++; $display("[TB] FAIL same_edge_clear: got %b expected 0", chk_busy1); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    chk_addr1 = 5'd12;
    alloc_valid = 1; alloc_addr = 5'd12;
    tick();
    alloc_valid = 0;
    alu_valid = 1; alu_addr = 5'd13; alu_data = 32'h13;
    lsu_valid = 1; lsu_addr = 5'd12; lsu_data = 32'hCC;
    tick();
    tick();
    #2;
    reset = 0;
    model_reset();
    #1;
    checks++; if (lsu_ready !== 1'b1 || write_enable !== 1'b0 || chk_busy1 !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_mid: got lsu=%b we=%b busy=%b expected 1 0 0", lsu_ready, write_enable, chk_busy1); end
    idle();
    tick();
    reset = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (write_enable !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_mid_stale: cycle %0d got %b expected 0", k, write_enable); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_addr  = ADDR_W'($urandom_range(0, 7));
      alu_valid   = ((c % 200) < 100) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
      alu_addr    = ADDR_W'($urandom_range(0, 7));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 1) == 1);
      lsu_addr    = ADDR_W'($urandom_range(0, 7));
      lsu_data    = $urandom;
      chk_addr1   = ADDR_W'($urandom_range(0, 7));
      chk_addr2   = ADDR_W'($urandom_range(0, 7));
      #1;
      checks++; if (alu_ready !== !m_hit() || lsu_ready !== (m_qa.size() < DEPTH)) begin
        failures++; $display("[TB] FAIL rand_ready: cycle %0d got alu=%b lsu=%b expected %b %b", c, alu_ready, lsu_ready, !m_hit(), m_qa.size() < DEPTH); end
      checks++; if (chk_busy1 !== m_busy(int'(chk_addr1)) || chk_busy2 !== m_busy(int'(chk_addr2))) begin
        failures++; $display("[TB] FAIL rand_busy: cycle %0d got %b%b expected %b%b", c, chk_busy1, chk_busy2, m_busy(int'(chk_addr1)), m_busy(int'(chk_addr2))); end
      tick();
      checks++; if (write_enable !== m_we || sb_overflow !== m_ovf) begin
        failures++; $display("[TB] FAIL rand_we: cycle %0d got we=%b ovf=%b expected %b %b", c, write_enable, sb_overflow, m_we, m_ovf); end
      if (m_we) begin
        checks++; if (write_addr !== ADDR_W'(m_wa) || write_data !== m_wd) begin
          failures++; $display("[TB] FAIL rand_write: cycle %0d got a=%0d d=%0h expected a=%0d d=%0h", c, write_addr, write_data, m_wa, m_wd); end
      end
    end
    idle();
  endtask

  initial begin
    reset = 0;
    idle();
    chk_addr1 = '0;
    chk_addr2 = '0;
    model_reset();
    test_reset();
    test_alu_write();
    test_lsu_latency();
    test_lsu_starve();
    test_overflow();
    test_x0();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
